// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipelined MIPS control unit.
//
// Contents: ISA opcode/funct constants, ALUOp codes, forwarding-select
// encodings, the decoded control bundle and the per-stage register layouts.
// Optional feature macro: JR_EN adds a jump_reg field to the control bundle.

package pipeline_ctrl_pkg;

    localparam int unsigned OpW            = 6;
    localparam int unsigned RegAddrW       = 5;
    localparam int unsigned AluOpW         = 3;
    localparam int unsigned LinkRegDefault = 31;

    // Opcodes (MIPS encodings)
    localparam logic [OpW-1:0] R_TYPE   = 6'h00;
    localparam logic [OpW-1:0] J        = 6'h02;
    localparam logic [OpW-1:0] JAL      = 6'h03;
    localparam logic [OpW-1:0] BEQ      = 6'h04;
    localparam logic [OpW-1:0] BNE      = 6'h05;
    localparam logic [OpW-1:0] ADDI     = 6'h08;
    localparam logic [OpW-1:0] ANDI     = 6'h0C;
    localparam logic [OpW-1:0] ORI      = 6'h0D;
    localparam logic [OpW-1:0] LUI      = 6'h0F;
    localparam logic [OpW-1:0] LW       = 6'h23;
    localparam logic [OpW-1:0] SW       = 6'h2B;
    localparam logic [OpW-1:0] FUNCT_JR = 6'h08;

    // ALUOp codes, shared with the single-cycle decoder
    localparam logic [AluOpW-1:0] ALUOP_R    = 3'd7;
    localparam logic [AluOpW-1:0] ALUOP_ADDI = 3'd6;
    localparam logic [AluOpW-1:0] ALUOP_ORI  = 3'd5;
    localparam logic [AluOpW-1:0] ALUOP_LUI  = 3'd4;
    localparam logic [AluOpW-1:0] ALUOP_LW   = 3'd3;
    localparam logic [AluOpW-1:0] ALUOP_SW   = 3'd2;
    localparam logic [AluOpW-1:0] ALUOP_ANDI = 3'd1;
    localparam logic [AluOpW-1:0] ALUOP_BR   = 3'd0;

    // EX operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic [AluOpW-1:0] alu_op;
        logic              alu_src;
        logic              branch_eq;
        logic              branch_ne;
        logic              jump;
        logic              jal;
`ifdef JR_EN
        logic              jump_reg;
`endif
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
    } ctrl_bundle_t;

    typedef struct packed {
        ctrl_bundle_t        ctrl;
        logic [RegAddrW-1:0] rs;
        logic [RegAddrW-1:0] rt;
        logic [RegAddrW-1:0] dest;
    } id_ex_t;

    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic                jal;
        logic [RegAddrW-1:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                jal;
        logic [RegAddrW-1:0] dest;
    } mem_wb_t;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_select(
        input logic                mem_reg_write,
        input logic [RegAddrW-1:0] mem_dest,
        input logic                wb_reg_write,
        input logic [RegAddrW-1:0] wb_dest,
        input logic [RegAddrW-1:0] src
    );
        if (mem_reg_write && (mem_dest == src)) begin
            return FWD_MEM;
        end
        if (wb_reg_write && (wb_dest == src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Bus between the pipeline datapath and the control unit.
//
// master: datapath side (drives ID fields and branch resolution, receives controls).
// slave : control unit side.
// Optional feature macro: JR_EN adds ex_jump_reg.

interface pipeline_control_unit_if #(
    parameter int unsigned OP_W       = pipeline_ctrl_pkg::OpW,
    parameter int unsigned REG_ADDR_W = pipeline_ctrl_pkg::RegAddrW,
    parameter int unsigned ALUOP_W    = pipeline_ctrl_pkg::AluOpW
);
    // ID stage inputs
    logic                  id_valid;
    logic [OP_W-1:0]       id_op;
    logic [OP_W-1:0]       id_funct;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  ex_branch_taken;

    // Hazard controls
    logic                  stall;
    logic                  if_id_flush;

    // EX stage
    logic [ALUOP_W-1:0]    ex_alu_op;
    logic                  ex_alu_src;
    logic                  ex_branch_eq;
    logic                  ex_branch_ne;
    logic                  ex_jump;
    logic                  ex_jal;
`ifdef JR_EN
    logic                  ex_jump_reg;
`endif
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;

    // MEM stage
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_dest;

    // WB stage
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic                  wb_jal;
    logic [REG_ADDR_W-1:0] wb_dest;

    modport master (
        output id_valid, id_op, id_funct, id_rs, id_rt, id_rd, ex_branch_taken,
`ifdef JR_EN
        input  ex_jump_reg,
`endif
        input  stall, if_id_flush,
        input  ex_alu_op, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal,
        input  ex_rs, ex_rt, ex_dest, fwd_a, fwd_b,
        input  mem_mem_read, mem_mem_write, mem_reg_write, mem_dest,
        input  wb_reg_write, wb_mem_to_reg, wb_jal, wb_dest
    );

    modport slave (
        input  id_valid, id_op, id_funct, id_rs, id_rt, id_rd, ex_branch_taken,
`ifdef JR_EN
        output ex_jump_reg,
`endif
        output stall, if_id_flush,
        output ex_alu_op, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal,
        output ex_rs, ex_rt, ex_dest, fwd_a, fwd_b,
        output mem_mem_read, mem_mem_write, mem_reg_write, mem_dest,
        output wb_reg_write, wb_mem_to_reg, wb_jal, wb_dest
    );

endinterface

// File: rtl/pipeline_control_unit_decode.sv
// ctrl_decode: combinational opcode decoder for the ID stage.
//
// Ports:
//   op_i       opcode
//   funct_i    funct field (only inspected when JR_EN is defined)
//   bundle_o   control bundle; unknown opcodes give all zeros
//   rs_used_o  instruction reads rs
//   rt_used_o  instruction reads rt
// Optional feature macro: JR_EN decodes R-type funct 0x08 as JR.
// RegWrite here is the raw opcode value; the top clears it for a zero destination.

module ctrl_decode
    import pipeline_ctrl_pkg::*;
(
    input  logic [OpW-1:0] op_i,
    input  logic [OpW-1:0] funct_i,
    output ctrl_bundle_t   bundle_o,
    output logic           rs_used_o,
    output logic           rt_used_o
);

`ifndef JR_EN
    logic unused_funct;
    assign unused_funct = ^funct_i;
`endif

    always_comb begin
        bundle_o  = '0;
        rs_used_o = 1'b1;
        rt_used_o = 1'b0;
        case (op_i)
            R_TYPE: begin
                bundle_o.alu_op    = ALUOP_R;
                bundle_o.reg_write = 1'b1;
                rt_used_o          = 1'b1;
`ifdef JR_EN
                if (funct_i == FUNCT_JR) begin
                    bundle_o.reg_write = 1'b0;
                    bundle_o.jump      = 1'b1;
                    bundle_o.jump_reg  = 1'b1;
                    rt_used_o          = 1'b0;
                end
`endif
            end
            ADDI: begin
                bundle_o.alu_op    = ALUOP_ADDI;
                bundle_o.alu_src   = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            ORI: begin
                bundle_o.alu_op    = ALUOP_ORI;
                bundle_o.alu_src   = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            LUI: begin
                bundle_o.alu_op    = ALUOP_LUI;
                bundle_o.alu_src   = 1'b1;
                bundle_o.reg_write = 1'b1;
                rs_used_o          = 1'b0;
            end
            LW: begin
                bundle_o.alu_op     = ALUOP_LW;
                bundle_o.alu_src    = 1'b1;
                bundle_o.reg_write  = 1'b1;
                bundle_o.mem_read   = 1'b1;
                bundle_o.mem_to_reg = 1'b1;
            end
            SW: begin
                bundle_o.alu_op    = ALUOP_SW;
                bundle_o.alu_src   = 1'b1;
                bundle_o.mem_write = 1'b1;
                rt_used_o          = 1'b1;
            end
            ANDI: begin
                bundle_o.alu_op    = ALUOP_ANDI;
                bundle_o.alu_src   = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            BEQ: begin
                bundle_o.alu_op    = ALUOP_BR;
                bundle_o.branch_eq = 1'b1;
                rt_used_o          = 1'b1;
            end
            BNE: begin
                bundle_o.alu_op    = ALUOP_BR;
                bundle_o.branch_ne = 1'b1;
                rt_used_o          = 1'b1;
            end
            J: begin
                bundle_o.jump = 1'b1;
                rs_used_o     = 1'b0;
            end
            JAL: begin
                bundle_o.jump      = 1'b1;
                bundle_o.jal       = 1'b1;
                bundle_o.reg_write = 1'b1;
                rs_used_o          = 1'b0;
            end
            default: begin
                // Unknown opcode: inert bubble that reads nothing.
                rs_used_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: control path of the 5-stage pipelined MIPS core.
//
// Decodes the ID instruction, carries its controls through ID/EX, EX/MEM and
// MEM/WB, and produces the load-use stall, the branch/jump flush and the EX
// operand forwarding selects.
//
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high; clears every stage register
//   bus    pipeline_control_unit_if.slave (ID fields in, stage controls out)
// Optional feature macro: JR_EN (JR decode and ex_jump_reg output).

module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LINK_REG = LinkRegDefault
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_control_unit_if.slave  bus
);

    ctrl_bundle_t        id_ctrl;
    logic                id_rs_used;
    logic                id_rt_used;
    logic [RegAddrW-1:0] id_dest;
    logic                load_use;

    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    ctrl_decode u_decode (
        .op_i      (bus.id_op),
        .funct_i   (bus.id_funct),
        .bundle_o  (id_ctrl),
        .rs_used_o (id_rs_used),
        .rt_used_o (id_rt_used)
    );

    always_comb begin
        id_dest = bus.id_rt;
        if (bus.id_op == R_TYPE) begin
            id_dest = bus.id_rd;
        end else if (bus.id_op == JAL) begin
            id_dest = RegAddrW'(LINK_REG);
        end
    end

    // Load in EX whose result a real ID instruction needs next cycle.
    assign load_use = bus.id_valid && id_ex_q.ctrl.mem_read && (id_ex_q.dest != '0) &&
                      (((id_ex_q.dest == bus.id_rs) && id_rs_used) ||
                       ((id_ex_q.dest == bus.id_rt) && id_rt_used));

    // A taken branch kills the ID instruction anyway, so it never also stalls.
    assign bus.stall       = load_use && !bus.ex_branch_taken && !reset;
    assign bus.if_id_flush = bus.ex_branch_taken && !reset;

    always_comb begin
        id_ex_d = '0;
        if (bus.id_valid && !load_use && !bus.ex_branch_taken) begin
            id_ex_d.ctrl           = id_ctrl;
            // Writes to $0 are dropped here so nothing downstream forwards them.
            id_ex_d.ctrl.reg_write = id_ctrl.reg_write && (id_dest != '0);
            id_ex_d.rs             = bus.id_rs;
            id_ex_d.rt             = bus.id_rt;
            id_ex_d.dest           = id_dest;
        end
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.mem_read   = id_ex_q.ctrl.mem_read;
        ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
        ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
        ex_mem_d.mem_to_reg = id_ex_q.ctrl.mem_to_reg;
        ex_mem_d.jal        = id_ex_q.ctrl.jal;
        ex_mem_d.dest       = id_ex_q.dest;
    end

    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.jal        = ex_mem_q.jal;
        mem_wb_d.dest       = ex_mem_q.dest;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.ex_alu_op    = id_ex_q.ctrl.alu_op;
    assign bus.ex_alu_src   = id_ex_q.ctrl.alu_src;
    assign bus.ex_branch_eq = id_ex_q.ctrl.branch_eq;
    assign bus.ex_branch_ne = id_ex_q.ctrl.branch_ne;
    assign bus.ex_jump      = id_ex_q.ctrl.jump;
    assign bus.ex_jal       = id_ex_q.ctrl.jal;
`ifdef JR_EN
    assign bus.ex_jump_reg  = id_ex_q.ctrl.jump_reg;
`endif
    assign bus.ex_rs        = id_ex_q.rs;
    assign bus.ex_rt        = id_ex_q.rt;
    assign bus.ex_dest      = id_ex_q.dest;

    assign bus.fwd_a = fwd_select(ex_mem_q.reg_write, ex_mem_q.dest,
                                  mem_wb_q.reg_write, mem_wb_q.dest, id_ex_q.rs);
    assign bus.fwd_b = fwd_select(ex_mem_q.reg_write, ex_mem_q.dest,
                                  mem_wb_q.reg_write, mem_wb_q.dest, id_ex_q.rt);

    assign bus.mem_mem_read  = ex_mem_q.mem_read;
    assign bus.mem_mem_write = ex_mem_q.mem_write;
    assign bus.mem_reg_write = ex_mem_q.reg_write;
    assign bus.mem_dest      = ex_mem_q.dest;

    assign bus.wb_reg_write  = mem_wb_q.reg_write;
    assign bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;
    assign bus.wb_jal        = mem_wb_q.jal;
    assign bus.wb_dest       = mem_wb_q.dest;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit.
// The reference model tracks whole instructions moving through EX, MEM and WB
// and derives every expected control from the instruction set rules.
// Builds with or without JR_EN.

module tb_pipeline_control_unit;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BAD  = 6'h3F;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;

    typedef struct packed {
        logic       valid;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src, beq, bne, jump, jal, jr;
        logic       mem_read, mem_write, reg_write, m2r, rs_used, rt_used;
        logic [4:0] rs, rt, dest;
    } info_t;

    typedef struct packed {
        logic       stall, flush;
        logic [8:0] ex_ctrl;
        logic [14:0] ex_regs;
        logic [3:0] fwd;
        logic [7:0] mem;
        logic [7:0] wb;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_control_unit_if bus ();

    pipeline_control_unit #(
        .LINK_REG (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_t ex_s, mem_s, wb_s;
    obs_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    logic [5:0] ops[12] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BAD};

    function automatic info_t info(input instr_t i);
        info_t r = '0;
        if (!i.valid) return r;
        r.rs = i.rs;
        r.rt = i.rt;
        r.dest = i.rt;
        r.rs_used = 1'b1;
        case (i.op)
            OP_R: begin
                r.alu_op = 3'd7; r.reg_write = 1'b1; r.rt_used = 1'b1; r.dest = i.rd;
`ifdef JR_EN
                if (i.funct == FN_JR) begin
                    r.reg_write = 1'b0; r.jump = 1'b1; r.jr = 1'b1; r.rt_used = 1'b0;
                end
`endif
            end
            OP_ADDI: begin r.alu_op = 3'd6; r.alu_src = 1'b1; r.reg_write = 1'b1; end
            OP_ORI:  begin r.alu_op = 3'd5; r.alu_src = 1'b1; r.reg_write = 1'b1; end
            OP_LUI: begin
                r.alu_op = 3'd4; r.alu_src = 1'b1; r.reg_write = 1'b1; r.rs_used = 1'b0;
            end
            OP_LW: begin
                r.alu_op = 3'd3; r.alu_src = 1'b1; r.reg_write = 1'b1;
                r.mem_read = 1'b1; r.m2r = 1'b1;
            end
            OP_SW: begin
                r.alu_op = 3'd2; r.alu_src = 1'b1; r.mem_write = 1'b1; r.rt_used = 1'b1;
            end
            OP_ANDI: begin r.alu_op = 3'd1; r.alu_src = 1'b1; r.reg_write = 1'b1; end
            OP_BEQ:  begin r.beq = 1'b1; r.rt_used = 1'b1; end
            OP_BNE:  begin r.bne = 1'b1; r.rt_used = 1'b1; end
            OP_J:    begin r.jump = 1'b1; r.rs_used = 1'b0; end
            OP_JAL: begin
                r.jump = 1'b1; r.jal = 1'b1; r.reg_write = 1'b1; r.dest = 5'd31;
                r.rs_used = 1'b0;
            end
            default: r.rs_used = 1'b0;
        endcase
        if (r.dest == 5'd0) r.reg_write = 1'b0;
        return r;
    endfunction

    function automatic logic [1:0] fwd_of(input info_t m, input info_t w, input logic [4:0] src);
        if (m.reg_write && m.dest == src) return 2'b10;
        if (w.reg_write && w.dest == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic obs_t expect_now(input instr_t id, input bit taken, input bit rst);
        info_t e = info(ex_s);
        info_t m = info(mem_s);
        info_t w = info(wb_s);
        info_t d = info(id);
        obs_t  o;
        o.stall = !rst && !taken && id.valid && e.mem_read && (e.dest != 0) &&
                  ((e.dest == id.rs && d.rs_used) || (e.dest == id.rt && d.rt_used));
        o.flush   = taken && !rst;
        o.ex_ctrl = {e.alu_op, e.alu_src, e.beq, e.bne, e.jump, e.jal, e.jr};
        o.ex_regs = {e.rs, e.rt, e.dest};
        o.fwd     = {fwd_of(m, w, e.rs), fwd_of(m, w, e.rt)};
        o.mem     = {m.mem_read, m.mem_write, m.reg_write, m.dest};
        o.wb      = {w.reg_write, w.m2r, w.jal, w.dest};
        return o;
    endfunction

    function automatic instr_t mk(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [5:0] funct);
        instr_t i;
        i.valid = 1'b1; i.op = op; i.funct = funct; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = ($urandom_range(0, 9) != 0);
        i.op    = ops[$urandom_range(0, 11)];
        i.funct = ($urandom_range(0, 1) == 0) ? FN_JR : FN_ADD;
        i.rs    = 5'($urandom_range(0, 3));
        i.rt    = 5'($urandom_range(0, 3));
        i.rd    = 5'($urandom_range(0, 3));
        if (i.op == OP_BAD) begin
            i.rs = 5'd0;
            i.rt = 5'd0;
        end
        return i;
    endfunction

    // Drive one cycle, queue its expected response, then advance the model at the edge.
    task automatic cycle(input instr_t id, input bit taken, input bit rst, input bit push,
                         output bit stalled);
        obs_t e;
        bus.id_valid        = id.valid;
        bus.id_op           = id.op;
        bus.id_funct        = id.funct;
        bus.id_rs           = id.rs;
        bus.id_rt           = id.rt;
        bus.id_rd           = id.rd;
        bus.ex_branch_taken = taken;
        reset               = rst;
        e = expect_now(id, taken, rst);
        if (push) sb_q.push_back(e);
        stalled = e.stall;
        @(posedge clk);
        if (rst) begin
            ex_s = '0; mem_s = '0; wb_s = '0;
        end else begin
            wb_s  = mem_s;
            mem_s = ex_s;
            ex_s  = (e.stall || taken) ? instr_t'('0) : id;
        end
        #1;
    endtask

    // Issue an instruction, re-presenting it while the pipeline holds IF/ID.
    task automatic run(input instr_t i, input bit taken);
        bit st;
        int guard = 0;
        do begin
            cycle(i, taken, 1'b0, 1'b1, st);
            guard++;
        end while (st && guard < 4);
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) run(instr_t'('0), 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
        end
    endtask

    obs_t mon_exp, mon_act;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            cyc++;
            mon_act.stall   = bus.stall;
            mon_act.flush   = bus.if_id_flush;
`ifdef JR_EN
            mon_act.ex_ctrl = {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch_eq,
                               bus.ex_branch_ne, bus.ex_jump, bus.ex_jal, bus.ex_jump_reg};
`else
            mon_act.ex_ctrl = {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch_eq,
                               bus.ex_branch_ne, bus.ex_jump, bus.ex_jal, 1'b0};
`endif
            mon_act.ex_regs = {bus.ex_rs, bus.ex_rt, bus.ex_dest};
            mon_act.fwd     = {bus.fwd_a, bus.fwd_b};
            mon_act.mem     = {bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write,
                               bus.mem_dest};
            mon_act.wb      = {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_jal, bus.wb_dest};
            chk("stall",       32'(mon_act.stall),   32'(mon_exp.stall));
            chk("if_id_flush", 32'(mon_act.flush),   32'(mon_exp.flush));
            chk("ex_ctrl",     32'(mon_act.ex_ctrl), 32'(mon_exp.ex_ctrl));
            chk("ex_regs",     32'(mon_act.ex_regs), 32'(mon_exp.ex_regs));
            chk("fwd_ab",      32'(mon_act.fwd),     32'(mon_exp.fwd));
            chk("mem_stage",   32'(mon_act.mem),     32'(mon_exp.mem));
            chk("wb_stage",    32'(mon_act.wb),      32'(mon_exp.wb));
        end
    end

    initial begin
        bit     st;
        bit     rst_r;
        bit     tk;
        instr_t cur;
        ex_s = '0; mem_s = '0; wb_s = '0;

        // Reset held for two cycles with a live ADDI and a taken branch.
        cycle(mk(OP_ADDI, 5'd1, 5'd3, 5'd0, 6'd0), 1'b0, 1'b1, 1'b0, st);
        cycle(mk(OP_ADDI, 5'd1, 5'd3, 5'd0, 6'd0), 1'b1, 1'b1, 1'b1, st);
        run(mk(OP_ADDI, 5'd1, 5'd3, 5'd0, 6'd0), 1'b0);
        nops(3);

        // Load-use: LW $8 then ADD $10 = $8 + $9
        run(mk(OP_LW, 5'd1, 5'd8, 5'd0, 6'd0), 1'b0);
        run(mk(OP_R, 5'd8, 5'd9, 5'd10, FN_ADD), 1'b0);
        nops(3);

        // Double forward: ADDI $5, ORI $5, ADD rs=$5
        run(mk(OP_ADDI, 5'd0, 5'd5, 5'd0, 6'd0), 1'b0);
        run(mk(OP_ORI, 5'd0, 5'd5, 5'd0, 6'd0), 1'b0);
        run(mk(OP_R, 5'd5, 5'd0, 5'd6, FN_ADD), 1'b0);
        nops(3);

        // Flush wins over a pending load-use stall
        run(mk(OP_LW, 5'd1, 5'd8, 5'd0, 6'd0), 1'b0);
        run(mk(OP_R, 5'd8, 5'd9, 5'd10, FN_ADD), 1'b1);
        nops(3);

        // JAL links to $31; ADD to $0 never writes or forwards
        run(mk(OP_JAL, 5'd0, 5'd0, 5'd0, 6'd0), 1'b0);
        nops(3);
        run(mk(OP_R, 5'd1, 5'd2, 5'd0, FN_ADD), 1'b0);
        run(mk(OP_ADDI, 5'd0, 5'd7, 5'd0, 6'd0), 1'b0);
        nops(3);

        // ADD $31 then JR $31
        run(mk(OP_R, 5'd1, 5'd2, 5'd31, FN_ADD), 1'b0);
        run(mk(OP_R, 5'd31, 5'd0, 5'd0, FN_JR), 1'b0);
        nops(3);

        // Reset mid-stream discards everything in flight
        run(mk(OP_LW, 5'd1, 5'd2, 5'd0, 6'd0), 1'b0);
        run(mk(OP_ADDI, 5'd2, 5'd3, 5'd0, 6'd0), 1'b0);
        cycle(mk(OP_R, 5'd3, 5'd2, 5'd4, FN_ADD), 1'b1, 1'b1, 1'b1, st);
        nops(3);

        // Randomized traffic; a stalled instruction is re-presented as IF/ID holds it.
        cur = rand_instr();
        for (int n = 0; n < 400; n++) begin
            rst_r = ($urandom_range(0, 99) == 0);
            tk    = ($urandom_range(0, 7) == 0);
            cycle(cur, tk, rst_r, 1'b1, st);
            if (!st) cur = rand_instr();
        end
        nops(2);

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Successor to the single-cycle opcode decoder for the 5-stage pipelined MIPS core.
- Decodes the ID-stage opcode into the control bundle (same instruction set and ALUOp codes as the single-cycle decoder) and resolves the destination register.
- Carries bundle and register addresses through ID/EX, EX/MEM and MEM/WB registers.
- Generates the load-use stall, branch/jump flush and EX operand-forwarding selects.

Parameters:
- OP_W, 6: opcode/funct width.
- REG_ADDR_W, 5: register-address width.
- ALUOP_W, 3: ALUOp width.
- LINK_REG, 31: destination register for JAL.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction; 0 decodes as bubble.
- id_op  in  OP_W  opcode of ID instruction.
- id_funct  in  OP_W  funct field (used only under JR_EN).
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  ID register fields.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- if_id_flush  out  1  zero IF/ID next edge (combinational).
- ex_alu_op  out  ALUOP_W; ex_alu_src, ex_branch_eq, ex_branch_ne, ex_jump, ex_jal  out  1 each.
- ex_rs, ex_rt, ex_dest  out  REG_ADDR_W each.
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- mem_mem_read, mem_mem_write, mem_reg_write  out  1 each; mem_dest  out  REG_ADDR_W.
- wb_reg_write, wb_mem_to_reg, wb_jal  out  1 each; wb_dest  out  REG_ADDR_W.

Behaviour:
- Decode, ALUOp values: R-type 7; ADDI 6; ORI 5; LUI 4; LW 3; SW 2; ANDI 1; BEQ/BNE/J/JAL 0.
- Unknown opcode decodes as an all-zero bundle.
- RegWrite set for R, ADDI, ORI, LUI, LW, ANDI, JAL.
- ALUSrc set for ADDI, ORI, LUI, LW, SW, ANDI.
- Destination: id_rd if R-type; LINK_REG if JAL; else id_rt. A resolved destination of 0 forces RegWrite to 0.
- Register usage: rs used by all except LUI, J, JAL; rt used by R, SW, BEQ, BNE.
- Latency: an instruction decoded in ID at edge n appears on ex_* after edge n+1, mem_* after n+2, wb_* after n+3. Bundle fields not needed downstream are dropped per stage.
- Load-use stall:
  - stall = ex_mem_read & ex_dest!=0 & ((ex_dest==id_rs & rs used) | (ex_dest==id_rt & rt used)) & id_valid & !ex_branch_taken.
  - On stall, ID/EX loads a bubble (all zero, including rs/rt/dest).
  - EX/MEM and MEM/WB advance normally.
- Flush: ex_branch_taken forces if_id_flush=1 and a bubble into ID/EX. Flush has priority over stall, so stall=0.
- Forwarding (per operand; shown for A using ex_rs, B uses ex_rt):
  - fwd_a=10 if mem_reg_write & mem_dest==ex_rs.
  - else 01 if wb_reg_write & wb_dest==ex_rs.
  - else 00.
  - EX/MEM wins when both match. Dest 0 never forwards (RegWrite already cleared).
- Reset: every stage register clears to 0 at the next clk edge with reset=1, so all ex_/mem_/wb_ outputs are 0, and stall=0, if_id_flush=0, fwd=00.
- Reset mid-stream discards all in-flight bundles; reset overrides stall and flush.
- No stall ever freezes EX/MEM or MEM/WB. There is no multi-cycle state beyond the stage registers.

Optional Feature:
- Macro JR_EN.
- When defined:
  - R-type with id_funct==6'h08 decodes as JR: RegWrite=0, rs used, rt unused, ex_jump=1.
  - Adds output ex_jump_reg (1), high for JR in EX.
- When undefined: funct is ignored and JR behaves as an ordinary R-type whose dest rd=0, so RegWrite is suppressed and no ex_jump_reg port exists.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - opcode localparams (R_TYPE, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL, FUNCT_JR);
  - ALUOp codes;
  - FWD_REG/FWD_MEM/FWD_WB encodings;
  - packed struct ctrl_bundle_t.
- One sub-module, ctrl_decode: combinational opcode to ctrl_bundle_t plus rs/rt-used flags. Pipeline registers, hazard and forwarding logic stay in the top.

Test Plan:
- Reset: reset=1 for 2 cycles with id_op=ADDI, id_valid=1 -> all outputs 0. First ADDI after release reaches ex_alu_op=6, ex_alu_src=1 one cycle later.
- Load-use stall:
  - LW rt=8, then ADD rs=8 rt=9 rd=10 -> stall=1 for exactly one cycle and ID/EX bubble (ex_alu_op=0).
  - ADD then reaches EX with fwd_a=01 (from MEM/WB).
- Double forward: ADDI $5, then ORI $5, then ADD rs=5 -> in ADD's EX cycle fwd_a=10 (EX/MEM wins over MEM/WB).
- Flush priority: ex_branch_taken=1 in the same cycle a load-use stall condition holds -> if_id_flush=1, stall=0, ID/EX bubble next edge.
- Link/zero: JAL -> wb_dest=31, wb_jal=1, wb_reg_write=1 at n+3. ADD rd=0 -> wb_reg_write=0 and no forwarding to a following rs=0 consumer.
- JR_EN: ADD $31 then JR $31 -> ex_jump_reg=1 with fwd_a=10. Without the macro, JR gives ex_alu_op=7 and wb_reg_write=0.
